// File: rtl/register_bank_multiport.sv
// register_bank_multiport: register bank with one synchronous write port,
// two independent registered read ports, same-cycle write-to-read
// forwarding, an optional hardwired-zero register 0 and a sequenced clear
// engine that zeroes one entry per cycle without asserting reset.
module register_bank_multiport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic [ADDR_WIDTH-1:0] writeNum,
  input  logic                  writeEnable,
  input  logic [ADDR_WIDTH-1:0] regNumA,
  input  logic                  readEnableA,
  output logic [DATA_WIDTH-1:0] dataOutA,
  input  logic [ADDR_WIDTH-1:0] regNumB,
  input  logic                  readEnableB,
  output logic [DATA_WIDTH-1:0] dataOutB,
  input  logic                  clearStart,
  output logic                  busy,
  output logic                  clearDone
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  // Terminal sweep index; compared explicitly so the sweep never relies on
  // the counter wrapping back to zero.
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] IDX_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
  localparam bit ZERO_EN = (ZERO_REG != 32'sd0);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                  state_r;
  logic [ADDR_WIDTH-1:0]   sweep_idx_r;
  logic                    busy_r;
  logic                    clear_done_r;
  logic [DATA_WIDTH-1:0]   regs_r [NUM_REGS];
  logic [DATA_WIDTH-1:0]   data_a_r;
  logic [DATA_WIDTH-1:0]   data_b_r;

  logic                    clearing_s;
  logic                    wr_accept_s;
  logic [DATA_WIDTH-1:0]   read_a_s;
  logic [DATA_WIDTH-1:0]   read_b_s;

  // Read value selection in priority order: hardwired zero, entry being
  // cleared this cycle, forwarded write data, then stored contents.
  function automatic logic [DATA_WIDTH-1:0] read_value(
    input logic [ADDR_WIDTH-1:0] idx,
    input logic                  clearing,
    input logic [ADDR_WIDTH-1:0] sweep_idx,
    input logic                  wr_accept,
    input logic [ADDR_WIDTH-1:0] wr_num,
    input logic [DATA_WIDTH-1:0] wr_data,
    input logic [DATA_WIDTH-1:0] stored
  );
    logic [DATA_WIDTH-1:0] value;
    if (ZERO_EN && (idx == IDX_ZERO)) begin
      value = DATA_ZERO;
    end else if (clearing && (idx == sweep_idx)) begin
      value = DATA_ZERO;
    end else if (wr_accept && (wr_num == idx)) begin
      value = wr_data;
    end else begin
      value = stored;
    end
    return value;
  endfunction

  // Decode whether this edge performs a write and what each read port sees.
  always_comb begin
    clearing_s  = (state_r == CLEAR);
    wr_accept_s = 1'b0;
    if (writeEnable && !clearing_s) begin
      if (ZERO_EN && (writeNum == IDX_ZERO)) begin
        wr_accept_s = 1'b0;
      end else begin
        wr_accept_s = 1'b1;
      end
    end else begin
      wr_accept_s = 1'b0;
    end
    read_a_s = read_value(regNumA, clearing_s, sweep_idx_r, wr_accept_s,
                          writeNum, dataIn, regs_r[regNumA]);
    read_b_s = read_value(regNumB, clearing_s, sweep_idx_r, wr_accept_s,
                          writeNum, dataIn, regs_r[regNumB]);
  end

  // Storage array: sweep clearing has priority, writes are blocked while clearing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= DATA_ZERO;
      end
    end else if (clearing_s) begin
      regs_r[sweep_idx_r] <= DATA_ZERO;
    end else if (wr_accept_s) begin
      regs_r[writeNum] <= dataIn;
    end
  end

  // Clear sequencer: IDLE waits for clearStart, CLEAR walks every index once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      sweep_idx_r  <= IDX_ZERO;
      busy_r       <= 1'b0;
      clear_done_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          clear_done_r <= 1'b0;
          sweep_idx_r  <= IDX_ZERO;
          if (clearStart) begin
            state_r <= CLEAR;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        CLEAR: begin
          if (sweep_idx_r == LAST_IDX) begin
            state_r      <= IDLE;
            sweep_idx_r  <= IDX_ZERO;
            busy_r       <= 1'b0;
            clear_done_r <= 1'b1;
          end else begin
            state_r      <= CLEAR;
            sweep_idx_r  <= sweep_idx_r + IDX_ONE;
            busy_r       <= 1'b1;
            clear_done_r <= 1'b0;
          end
        end
        default: begin
          state_r      <= IDLE;
          sweep_idx_r  <= IDX_ZERO;
          busy_r       <= 1'b0;
          clear_done_r <= 1'b0;
        end
      endcase
    end
  end

  // Registered read ports; each holds its value while its enable is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_a_r <= DATA_ZERO;
      data_b_r <= DATA_ZERO;
    end else begin
      if (readEnableA) begin
        data_a_r <= read_a_s;
      end
      if (readEnableB) begin
        data_b_r <= read_b_s;
      end
    end
  end

  assign dataOutA  = data_a_r;
  assign dataOutB  = data_b_r;
  assign busy      = busy_r;
  assign clearDone = clear_done_r;

endmodule

// File: tb/tb_register_bank_multiport.sv
// Bench for register_bank_multiport: two instances (ZERO_REG=1 and 0) share
// the stimulus; a reference model predicts every cycle's outputs into a
// scoreboard queue that a separate monitor drains on the falling edge.
module tb_register_bank_multiport;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] din;
  logic [3:0]  wn;
  logic        we;
  logic [3:0]  ra;
  logic        ea;
  logic [3:0]  rb;
  logic        eb;
  logic        cs;

  logic [31:0] a1, b1, a0, b0;
  logic        busy1, done1, busy0, done0;

  always #5 clk = ~clk;

  register_bank_multiport #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .ZERO_REG(1)) u_z1 (
    .clk(clk), .reset(reset), .dataIn(din), .writeNum(wn), .writeEnable(we),
    .regNumA(ra), .readEnableA(ea), .dataOutA(a1),
    .regNumB(rb), .readEnableB(eb), .dataOutB(b1),
    .clearStart(cs), .busy(busy1), .clearDone(done1));

  register_bank_multiport #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .ZERO_REG(0)) u_z0 (
    .clk(clk), .reset(reset), .dataIn(din), .writeNum(wn), .writeEnable(we),
    .regNumA(ra), .readEnableA(ea), .dataOutA(a0),
    .regNumB(rb), .readEnableB(eb), .dataOutB(b0),
    .clearStart(cs), .busy(busy0), .clearDone(done0));

  typedef struct {
    logic [31:0] a0, b0, a1, b1;
    logic        busy, done;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: register contents as plain storage, the sweep as the
  // edge number at which it started.
  logic [31:0] mem [16];
  bit          active;
  int          start_cyc;
  int          cyc;
  logic [31:0] oa0, ob0, oa1, ob1;
  bit          done_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mread(input int idx, input bit zr, input bit in_clear,
                                        input int sidx, input bit wacc);
    if (zr && idx == 0) return 32'h0;
    if (in_clear && idx == sidx) return 32'h0;
    if (wacc && int'(wn) == idx) return din;
    return mem[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    active = 1'b0; done_m = 1'b0; start_cyc = 0;
    oa0 = 32'h0; ob0 = 32'h0; oa1 = 32'h0; ob1 = 32'h0;
    q.delete();
  endtask

  // One clock edge: update the model with the inputs present at the edge.
  task automatic step();
    bit in_clear;
    int sidx;
    bit wacc;
    logic [31:0] va0, va1, vb0, vb1;
    exp_t e;
    @(posedge clk);
    in_clear = active;
    sidx = cyc - start_cyc - 1;
    wacc = we && !in_clear;
    va0 = mread(int'(ra), 1'b0, in_clear, sidx, wacc);
    va1 = mread(int'(ra), 1'b1, in_clear, sidx, wacc);
    vb0 = mread(int'(rb), 1'b0, in_clear, sidx, wacc);
    vb1 = mread(int'(rb), 1'b1, in_clear, sidx, wacc);
    if (in_clear) begin
      mem[sidx] = 32'h0;
      if (sidx == 15) begin
        active = 1'b0;
        done_m = 1'b1;
      end else begin
        done_m = 1'b0;
      end
    end else begin
      done_m = 1'b0;
      if (wacc) mem[wn] = din;
      if (cs) begin
        active = 1'b1;
        start_cyc = cyc;
      end
    end
    if (ea) begin oa0 = va0; oa1 = va1; end
    if (eb) begin ob0 = vb0; ob1 = vb1; end
    e.a0 = oa0; e.b0 = ob0; e.a1 = oa1; e.b1 = ob1;
    e.busy = active; e.done = done_m;
    q.push_back(e);
    cyc++;
    #1;
  endtask

  task automatic cycle(input bit w, input logic [3:0] wi, input logic [31:0] d,
                       input logic [3:0] rai, input bit rae,
                       input logic [3:0] rbi, input bit rbe, input bit c);
    we = w; wn = wi; din = d; ra = rai; ea = rae; rb = rbi; eb = rbe; cs = c;
    step();
  endtask

  // Monitor: every edge presents a new output state; compare it to the head.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("dataOutA_z0", a0, e.a0);
      check("dataOutB_z0", b0, e.b0);
      check("dataOutA_z1", a1, e.a1);
      check("dataOutB_z1", b1, e.b1);
      check("busy", {31'h0, busy1}, {31'h0, e.busy});
      check("clearDone", {31'h0, done1}, {31'h0, e.done});
      check("busy_z0", {31'h0, busy0}, {31'h0, e.busy});
      check("clearDone_z0", {31'h0, done0}, {31'h0, e.done});
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_A_z1"}, a1, 32'h0);
    check({tag, "_B_z1"}, b1, 32'h0);
    check({tag, "_A_z0"}, a0, 32'h0);
    check({tag, "_B_z0"}, b0, 32'h0);
    check({tag, "_busy"}, {30'h0, busy1, busy0}, 32'h0);
    check({tag, "_done"}, {30'h0, done1, done0}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    we = 1'b0; wn = 4'h0; din = 32'h0; ra = 4'h0; ea = 1'b0; rb = 4'h0; eb = 1'b0; cs = 1'b0;
    cyc = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    // Walk ones-fill: write i, read i on A (forwarded) and i-1 on B.
    for (int i = 1; i < 16; i++)
      cycle(1'b1, 4'(i), 32'hFFFF_FFFF, 4'(i), 1'b1, 4'(i - 1), 1'b1, 1'b0);

    // Register 0 behaviour differs between the two instances.
    cycle(1'b1, 4'h0, 32'hDEAD_BEEF, 4'h1, 1'b0, 4'h1, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0);

    // Forwarding on both ports, then a plain read of the stored value.
    cycle(1'b1, 4'h5, 32'h1111_1111, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    cycle(1'b1, 4'h5, 32'h2222_2222, 4'h5, 1'b1, 4'h5, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 32'h0, 4'h5, 1'b1, 4'h5, 1'b1, 1'b0);

    // Hold: port A disabled while its index is rewritten.
    cycle(1'b0, 4'h0, 32'h0, 4'h7, 1'b1, 4'h7, 1'b0, 1'b0);
    cycle(1'b1, 4'h7, 32'h7777_0001, 4'h7, 1'b0, 4'h7, 1'b0, 1'b0);
    cycle(1'b1, 4'h7, 32'h7777_0002, 4'h7, 1'b0, 4'h3, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 32'h0, 4'h7, 1'b1, 4'h7, 1'b0, 1'b0);

    // Randomised traffic, including occasional sweeps.
    for (int i = 0; i < 250; i++)
      cycle($urandom_range(0, 1) == 1, 4'($urandom), $urandom, 4'($urandom),
            $urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 39) == 0);
    repeat (18) cycle(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);

    // Sweep: fill with A5A5A5A5, clear, writes dropped, restart ignored.
    for (int i = 0; i < 16; i++)
      cycle(1'b1, 4'(i), 32'hA5A5_A5A5, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
    for (int k = 1; k <= 16; k++)
      cycle(1'b1, 4'($urandom), $urandom, 4'hF, k == 3, 4'($urandom), 1'b1, k == 5);
    cycle(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 32'h0, 4'hF, 1'b1, 4'h9, 1'b1, 1'b0);

    // Reset at sweep cycle 7 aborts the sweep.
    for (int i = 0; i < 16; i++)
      cycle(1'b1, 4'(i), 32'h5A5A_0000 + i, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
    for (int k = 1; k <= 7; k++)
      cycle(1'b0, 4'h0, 32'h0, 4'hE, 1'b1, 4'h1, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    check_reset_outputs("midsweep_reset");
    model_reset();
    #1;
    reset = 1'b0;
    cycle(1'b1, 4'h3, 32'h1234_5678, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 32'h0, 4'h3, 1'b1, 4'hE, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++)
      cycle(1'b0, 4'h0, 32'h0, 4'(i), 1'b1, 4'(15 - i), 1'b1, 1'b0);

    @(negedge clk);
    #1;
    check("scoreboard_drained", q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
